counter_2: RTL and testbench



---
 rtl/counter_2.sv | 67 ++++++
 tb/tb_counter_2.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/counter_2.sv
// Frame-synchronous C4 clock converter: locks a bit counter to the active-low F0
// pulse and decodes CLK1/CLK2 plus their enables. Optional flywheel: COUNTER_2_FREERUN_EN.
module counter_2 #(
   parameter int FRAME_LEN = 512,
   parameter int DIV2_LOG  = 3
) (
   input  logic c4,
   input  logic reset,
   input  logic f0,
   output logic clk_en1,
   output logic clk_en2,
   output logic clk1,
   output logic clk2
);

   localparam int              CW   = $clog2(FRAME_LEN);
   localparam logic [CW-1:0]   LAST = CW'(FRAME_LEN - 1);

   logic          f0_s_q, f0_d_q;
   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start;

   // Falling edge of the twice-sampled F0; a long low pulse yields one start.
   assign start = f0_d_q & ~f0_s_q;

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
`ifndef COUNTER_2_FREERUN_EN
            run_d = 1'b0;
`endif
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge c4) begin
      if (!reset) begin
         f0_s_q <= 1'b1;
         f0_d_q <= 1'b1;
         run_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         f0_s_q <= f0;
         f0_d_q <= f0_s_q;
         run_q  <= run_d;
         cnt_q  <= cnt_d;
      end
   end

   // Decoded only from registered state, so no input reaches an output combinationally.
   always_comb begin
      clk1    = run_q & ~cnt_q[0];
      clk2    = run_q & ~cnt_q[DIV2_LOG-1];
      clk_en1 = run_q & cnt_q[0];
      clk_en2 = run_q & (&cnt_q[DIV2_LOG-1:0]);
   end

endmodule

// File: tb/tb_counter_2.sv
// Directed bench for counter_2: frame-relative model plus hand-computed checkpoints.
module tb_counter_2;

   localparam int FRAME_LEN = 512;
   localparam int DIV2_LOG  = 3;
   localparam int P2        = 1 << DIV2_LOG;

   logic c4 = 1'b0;
   logic reset, f0;
   logic clk_en1, clk_en2, clk1, clk2;
   logic [3:0] outs;

   counter_2 #(.FRAME_LEN(FRAME_LEN), .DIV2_LOG(DIV2_LOG)) dut (
      .c4(c4), .reset(reset), .f0(f0),
      .clk_en1(clk_en1), .clk_en2(clk_en2), .clk1(clk1), .clk2(clk2)
   );

   always #5 c4 = ~c4;
   assign outs = {clk1, clk2, clk_en1, clk_en2};

   // Model: cycles elapsed since the last frame start (-1 = not running).
   int   m_since = -1;
   logic m_p1 = 1'b1, m_p2 = 1'b1;
   logic armed = 1'b0;
   logic [3:0] model_exp;

   function automatic logic [3:0] exp_of(input int s);
      int c;
      if (s < 0) return 4'b0000;
      c = s % FRAME_LEN;
      return {(c % 2) == 0, (c % P2) < (P2 / 2), (c % 2) == 1, (c % P2) == (P2 - 1)};
   endfunction

   always_comb model_exp = exp_of(m_since);

   always @(posedge c4) begin
      if (!reset) begin
         m_since <= -1;
         m_p1    <= 1'b1;
         m_p2    <= 1'b1;
         armed   <= 1'b1;
      end else begin
         m_p1 <= f0;
         m_p2 <= m_p1;
         if (!m_p1 && m_p2)
            m_since <= 0;
         else if (m_since >= 0) begin
`ifdef COUNTER_2_FREERUN_EN
            m_since <= m_since + 1;
`else
            m_since <= (m_since + 1 >= FRAME_LEN) ? -1 : m_since + 1;
`endif
         end
      end
   end

   int         nvec = 0, nmis = 0;
   int         lit_seq = 0, lit_done = 0;
   string      lit_name;
   logic [3:0] lit_exp;

   initial begin
      forever begin
         @(negedge c4);
         if (armed) begin
            nvec++;
            if (outs !== model_exp) begin
               nmis++;
               $display("FAIL model_cycle t=%0t dut=%b expected=%b", $time, outs, model_exp);
            end
         end
         if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            nvec++;
            if (outs !== lit_exp) begin
               nmis++;
               $display("FAIL %s t=%0t dut=%b expected=%b", lit_name, $time, outs, lit_exp);
            end
            nvec++;
            if (model_exp !== lit_exp) begin
               nmis++;
               $display("FAIL %s_model t=%0t model=%b expected=%b", lit_name, $time, model_exp, lit_exp);
            end
         end
      end
   end

   task automatic cyc(input logic f0v, input logic rv);
      @(negedge c4);
      f0    = f0v;
      reset = rv;
      @(posedge c4);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1);
   endtask

   task automatic lit(input string nm, input logic [3:0] e);
      lit_name = nm;
      lit_exp  = e;
      lit_seq++;
   endtask

   initial begin
      f0    = 1'b1;
      reset = 1'b0;
      // outs = {clk1, clk2, clk_en1, clk_en2}
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0);
         lit("reset_hold", 4'b0000);
      end
      cyc(1'b1, 1'b1);  lit("idle", 4'b0000);
      cyc(1'b0, 1'b1);  lit("f0_sampled", 4'b0000);
      cyc(1'b1, 1'b1);  lit("cnt0", 4'b1100);
      cyc(1'b1, 1'b1);  lit("cnt1", 4'b0110);
      run(6);           lit("cnt7_en2", 4'b0011);
      // frames of 500 cycles: resync before reaching 511
      run(491);
      for (int f = 0; f < 3; f++) begin
         cyc(1'b0, 1'b1); lit("pre_resync_cnt499", 4'b0110);
         cyc(1'b1, 1'b1); lit("resync_cnt0", 4'b1100);
         if (f < 2) run(498);
      end
      // f0 held low 5 cycles
      run(10);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
      lit("held_cnt3", 4'b0110);
      cyc(1'b1, 1'b1);  lit("held_cnt4", 4'b1000);
      // f0 stops: wrap behaviour
      run(507);         lit("cnt511", 4'b0011);
      cyc(1'b1, 1'b1);
`ifdef COUNTER_2_FREERUN_EN
      lit("after_wrap", 4'b1100);
      run(20);          lit("flywheel_cnt20", 4'b1000);
`else
      lit("after_wrap", 4'b0000);
      run(20);          lit("stopped", 4'b0000);
`endif
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);  lit("restart", 4'b1100);
      // reset mid-frame
      run(200);         lit("cnt200", 4'b1100);
      cyc(1'b1, 1'b0);  lit("reset_mid", 4'b0000);
      run(10);          lit("wait_f0", 4'b0000);
      cyc(1'b0, 1'b1);  lit("f0_after_reset", 4'b0000);
      cyc(1'b1, 1'b1);  lit("restart2", 4'b1100);
      run(3);           lit("restart2_cnt3", 4'b0110);
      repeat (2) @(negedge c4);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
